keypad_operand_entry: RTL and testbench

- Input-side counterpart of the time-multiplexed 7-segment display driver.
- The display scans anodes outward; this block scans the columns of a 4x4 hex keypad and reads its rows back in.
- It debounces key presses and shifts each accepted hex digit into a 32-bit operand register.
- That register is the operand source for the ALU datapath, replacing raw slide-switch operands.

---
 rtl/keypad_operand_entry_if.sv | 21 ++
 rtl/keypad_operand_entry.sv | 150 +++++++++++++++
 tb/tb_keypad_operand_entry.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_operand_entry_if.sv
// Keypad/operand bus for keypad_operand_entry: keypad row/column lines, clear and
// the accepted-key outputs. The slave modport is the entry block, the master is its user.
interface keypad_operand_entry_if;
    logic [3:0]  i_row;
    logic        i_clr;
    logic [3:0]  o_col;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic [31:0] o_operand;
    logic [3:0]  o_digit_count;

    modport slave (
        input  i_row, i_clr,
        output o_col, o_key_valid, o_key_code, o_operand, o_digit_count
    );

    modport master (
        output i_row, i_clr,
        input  o_col, o_key_valid, o_key_code, o_operand, o_digit_count
    );
endinterface

// File: rtl/keypad_operand_entry.sv
// 4x4 hex keypad scanner with frame-level press/release debounce that shifts each
// accepted digit into a 32-bit operand register.
module keypad_operand_entry #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    keypad_operand_entry_if.slave  bus
);
    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DF        = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col_idx;
    logic              r_hit;
    logic [3:0]        r_hit_code;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [3:0]        r_cand;
    logic              r_key_valid;
    logic [3:0]        r_key_code;
    logic [31:0]       r_operand;
    logic [3:0]        r_digit_count;

    logic              w_sample;
    logic              w_frame_end;
    logic              w_slot_hit;
    logic              w_frame_hit;
    logic              w_accept;
    logic [1:0]        w_row_idx;
    logic [3:0]        w_slot_code;
    logic [3:0]        w_frame_code;
    logic [3:0]        w_cnt_next;

    // Lowest-numbered low row wins within a column; earlier columns win across the frame.
    always_comb begin
        w_row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_sync2[r]) w_row_idx = 2'(r);
        end
    end

    assign w_sample     = (r_slot == SLOT_LAST);
    assign w_frame_end  = w_sample && (r_col_idx == 2'd3);
    assign w_slot_hit   = ~&r_sync2;
    assign w_slot_code  = {w_row_idx, r_col_idx};
    assign w_frame_hit  = r_hit | w_slot_hit;
    assign w_frame_code = r_hit ? r_hit_code : w_slot_code;
    assign w_cnt_next   = r_cnt + 4'd1;
    assign w_accept     = w_frame_end && w_frame_hit &&
                          (((r_state == IDLE) && (DF == 4'd1)) ||
                           ((r_state == DEBOUNCE) && (w_frame_code == r_cand) && (w_cnt_next == DF)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_slot     <= '0;
            r_col_idx  <= 2'd0;
            r_hit      <= 1'b0;
            r_hit_code <= 4'd0;
        end else begin
            r_sync1 <= bus.i_row;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_slot    <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                if (r_col_idx == 2'd3) begin
                    r_hit <= 1'b0;
                end else if (!r_hit && w_slot_hit) begin
                    r_hit      <= 1'b1;
                    r_hit_code <= w_slot_code;
                end
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

    // Debounce FSM steps once per frame; clr only touches the operand and digit count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_cand        <= 4'd0;
            r_key_valid   <= 1'b0;
            r_key_code    <= 4'd0;
            r_operand     <= 32'd0;
            r_digit_count <= 4'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) r_key_code <= w_frame_code;

            if (bus.i_clr) begin
                r_operand     <= 32'd0;
                r_digit_count <= 4'd0;
            end else if (w_accept) begin
                r_operand <= {r_operand[27:0], w_frame_code};
                if (r_digit_count != 4'd8) r_digit_count <= r_digit_count + 4'd1;
            end

            if (w_frame_end) begin
                case (r_state)
                    IDLE: begin
                        if (w_frame_hit) begin
                            r_cand  <= w_frame_code;
                            r_cnt   <= 4'd1;
                            r_state <= (DF == 4'd1) ? PRESSED : DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_frame_hit && (w_frame_code == r_cand)) begin
                            r_cnt <= w_cnt_next;
                            if (w_cnt_next == DF) r_state <= PRESSED;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (!w_frame_hit) begin
                            r_cnt   <= 4'd1;
                            r_state <= (DF == 4'd1) ? IDLE : RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!w_frame_hit) begin
                            r_cnt <= w_cnt_next;
                            if (w_cnt_next == DF) r_state <= IDLE;
                        end else begin
                            r_state <= PRESSED;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_col         = ~(4'b0001 << r_col_idx);
    assign bus.o_key_valid   = r_key_valid;
    assign bus.o_key_code    = r_key_code;
    assign bus.o_operand     = r_operand;
    assign bus.o_digit_count = r_digit_count;
endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: a keypad model drives rows from the scanned columns,
// and a frame-level reference model predicts accepted keys and the operand register.
module tb_keypad_operand_entry;
    localparam int DF = 3;

    logic clk = 1'b0;
    logic reset;

    keypad_operand_entry_if intf();

    keypad_operand_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Keypad: key r*4+c shorts row r to column c.
    logic [15:0] keyMask;
    logic [3:0]  rowDrive;
    always_comb begin
        rowDrive = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keyMask[r*4+c] && !intf.o_col[c]) rowDrive[r] = 1'b0;
    end
    assign intf.i_row = rowDrive;

    logic [3:0] colSeq [4];

    // Reference model, one step per frame.
    bit          mArmed;
    int          mRun;
    int          mRunKey;
    int          mNoneRun;
    logic [31:0] mOperand;
    int          mCount;
    logic [3:0]  mCode;

    task automatic modelReset();
        mArmed = 1; mRun = 0; mRunKey = 0; mNoneRun = 0;
        mOperand = 32'd0; mCount = 0; mCode = 4'd0;
    endtask

    function automatic int frameResult(input logic [15:0] m);
        int res;
        res = -1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4+c] && res < 0) res = r*4 + c;
        return res;
    endfunction

    task automatic modelFrame(input int res, output bit accept);
        accept = 0;
        if (mArmed) begin
            if (res < 0) mRun = 0;
            else if (mRun > 0 && res != mRunKey) mRun = 0;
            else begin
                if (mRun == 0) mRunKey = res;
                mRun++;
            end
            if (mRun == DF) begin
                accept = 1; mArmed = 0; mNoneRun = 0; mCode = 4'(mRunKey);
            end
        end else begin
            if (res < 0) begin
                mNoneRun++;
                if (mNoneRun == DF) begin mArmed = 1; mRun = 0; end
            end else begin
                mNoneRun = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs whole frames with a fixed key mask, optionally pulsing clr on one cycle.
    task automatic applyStimulus(input logic [15:0] mask, input int frames, input int clrFrame,
                                 input int clrIter, output int pulses, output int pulseFrame);
        int res;
        bit accept;
        bit clrThis;
        int colBad;
        int pulseBad;
        pulses = 0;
        pulseFrame = -1;
        keyMask = mask;
        for (int f = 0; f < frames; f++) begin
            res = frameResult(mask);
            modelFrame(res, accept);
            clrThis = (f == clrFrame);
            colBad = 0;
            pulseBad = 0;
            for (int it = 1; it <= 16; it++) begin
                intf.i_clr = clrThis && (it == clrIter);
                @(posedge clk); #1;
                if (intf.o_col !== colSeq[(it/4)%4]) colBad++;
                if (intf.o_key_valid !== (accept && it == 16)) pulseBad++;
                if (intf.o_key_valid === 1'b1) begin
                    pulses++;
                    if (pulseFrame < 0) pulseFrame = f;
                end
            end
            intf.i_clr = 1'b0;
            if (clrThis) begin mOperand = 32'd0; mCount = 0; end
            if (accept && !(clrThis && clrIter == 16)) begin
                mOperand = {mOperand[27:0], 4'(res)};
                if (mCount < 8) mCount++;
            end
            checkOutput("col scan errors", colBad, 0);
            checkOutput("key_valid timing errors", pulseBad, 0);
            checkOutput("model key_code", intf.o_key_code, mCode);
            checkOutput("model operand", intf.o_operand, mOperand);
            checkOutput("model digit_count", intf.o_digit_count, mCount);
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          expPulses;
        logic [3:0]  expCode;
        logic [31:0] expOperand;
        logic [3:0]  expCount;
        bit          releaseAfter;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int pulses;
        int pf;
        int total;
        logic [15:0] rmask;
        int hold;
        int cIter;

        colSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0]  = '{16'h0040, 2, 0, 4'h0, 32'h0,        4'd0, 1'b0};
        vecs[1]  = '{16'h0040, 1, 1, 4'h6, 32'h6,        4'd1, 1'b0};
        vecs[2]  = '{16'h0040, 7, 0, 4'h6, 32'h6,        4'd1, 1'b1};
        vecs[3]  = '{16'h0002, 3, 1, 4'h1, 32'h61,       4'd2, 1'b1};
        vecs[4]  = '{16'h0004, 3, 1, 4'h2, 32'h612,      4'd3, 1'b1};
        vecs[5]  = '{16'h0008, 3, 1, 4'h3, 32'h6123,     4'd4, 1'b1};
        vecs[6]  = '{16'h0400, 3, 1, 4'hA, 32'h6123A,    4'd5, 1'b1};
        vecs[7]  = '{16'h0800, 3, 1, 4'hB, 32'h6123AB,   4'd6, 1'b1};
        vecs[8]  = '{16'h1000, 3, 1, 4'hC, 32'h6123ABC,  4'd7, 1'b1};
        vecs[9]  = '{16'h2000, 3, 1, 4'hD, 32'h6123ABCD, 4'd8, 1'b1};
        vecs[10] = '{16'h4000, 3, 1, 4'hE, 32'h123ABCDE, 4'd8, 1'b1};
        vecs[11] = '{16'h8000, 3, 1, 4'hF, 32'h23ABCDEF, 4'd8, 1'b1};

        reset = 1'b1;
        intf.i_clr = 1'b0;
        keyMask = 16'h0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset col", intf.o_col, 4'b1110);
        checkOutput("reset key_valid", intf.o_key_valid, 0);
        checkOutput("reset key_code", intf.o_key_code, 0);
        checkOutput("reset operand", intf.o_operand, 0);
        checkOutput("reset digit_count", intf.o_digit_count, 0);

        // Key 6 held, then a run of keys with full releases.
        total = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].mask, vecs[i].frames, -1, 0, pulses, pf);
            if (i >= 3) total += pulses;
            checkOutput("table pulses", pulses, vecs[i].expPulses);
            checkOutput("table key_code", intf.o_key_code, vecs[i].expCode);
            checkOutput("table operand", intf.o_operand, vecs[i].expOperand);
            checkOutput("table digit_count", intf.o_digit_count, vecs[i].expCount);
            if (vecs[i].releaseAfter) begin
                applyStimulus(16'h0, 3, -1, 0, pulses, pf);
                checkOutput("table release pulses", pulses, 0);
            end
        end
        checkOutput("sequence pulse total", total, 9);

        // Bouncing key 5, then stable.
        total = 0;
        for (int b = 0; b < 8; b++) begin
            applyStimulus((b % 2 == 0) ? 16'h0020 : 16'h0000, 1, -1, 0, pulses, pf);
            total += pulses;
        end
        checkOutput("bounce pulses", total, 0);
        applyStimulus(16'h0020, 4, -1, 0, pulses, pf);
        checkOutput("bounce stable pulses", pulses, 1);
        checkOutput("bounce pulse frame", pf, 2);
        checkOutput("bounce key_code", intf.o_key_code, 5);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);

        // Keys 0 and 15 together, partial release, incomplete full release.
        applyStimulus(16'h8001, 3, -1, 0, pulses, pf);
        checkOutput("multi pulses", pulses, 1);
        checkOutput("multi key_code", intf.o_key_code, 0);
        applyStimulus(16'h8000, 5, -1, 0, pulses, pf);
        checkOutput("partial release pulses", pulses, 0);
        applyStimulus(16'h0, 2, -1, 0, pulses, pf);
        applyStimulus(16'h8000, 4, -1, 0, pulses, pf);
        checkOutput("short release pulses", pulses, 0);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);
        applyStimulus(16'h8000, 3, -1, 0, pulses, pf);
        checkOutput("key15 pulses", pulses, 1);
        checkOutput("key15 key_code", intf.o_key_code, 4'hF);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);

        // Clear, build 0x12, then clr during key 9's key_valid cycle.
        applyStimulus(16'h0, 1, 0, 5, pulses, pf);
        checkOutput("clr operand", intf.o_operand, 0);
        checkOutput("clr digit_count", intf.o_digit_count, 0);
        applyStimulus(16'h0002, 3, -1, 0, pulses, pf);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);
        applyStimulus(16'h0004, 3, -1, 0, pulses, pf);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);
        checkOutput("pre-clr operand", intf.o_operand, 32'h12);
        applyStimulus(16'h0200, 3, -1, 0, pulses, pf);
        checkOutput("key9 pulses", pulses, 1);
        applyStimulus(16'h0200, 1, 0, 1, pulses, pf);
        checkOutput("clr-on-valid operand", intf.o_operand, 0);
        checkOutput("clr-on-valid digit_count", intf.o_digit_count, 0);
        checkOutput("clr-on-valid key_code", intf.o_key_code, 9);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);

        // clr on the very edge that accepts key 3: clear wins, key_code still updates.
        applyStimulus(16'h0008, 3, 2, 16, pulses, pf);
        checkOutput("clr-at-accept pulses", pulses, 1);
        checkOutput("clr-at-accept operand", intf.o_operand, 0);
        checkOutput("clr-at-accept key_code", intf.o_key_code, 3);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);
        applyStimulus(16'h0010, 3, -1, 0, pulses, pf);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);

        // Reset mid-debounce with key 7 held.
        applyStimulus(16'h0080, 1, -1, 0, pulses, pf);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async reset col", intf.o_col, 4'b1110);
        checkOutput("async reset key_valid", intf.o_key_valid, 0);
        checkOutput("async reset key_code", intf.o_key_code, 0);
        checkOutput("async reset operand", intf.o_operand, 0);
        checkOutput("async reset digit_count", intf.o_digit_count, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(16'h0080, 5, -1, 0, pulses, pf);
        checkOutput("post-reset pulses", pulses, 1);
        checkOutput("post-reset pulse frame", pf, 2);
        checkOutput("post-reset key_code", intf.o_key_code, 7);
        applyStimulus(16'h0, 3, -1, 0, pulses, pf);

        // Randomized frames against the reference model.
        rmask = 16'h0;
        hold = 0;
        for (int n = 0; n < 160; n++) begin
            if (hold == 0) begin
                int sel;
                sel = $urandom_range(0, 9);
                rmask = 16'h0;
                if (sel >= 4) rmask[$urandom_range(0, 15)] = 1'b1;
                if (sel >= 8) rmask[$urandom_range(0, 15)] = 1'b1;
                hold = $urandom_range(1, 5);
            end
            cIter = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 16) : 0;
            applyStimulus(rmask, 1, (cIter != 0) ? 0 : -1, cIter, pulses, pf);
            hold--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
